// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests, handles LBU/SB byte lanes, stalls upstream while an access is outstanding.
// Optional access-abort timer is built in when MEM_STAGE_TIMEOUT_EN is defined; otherwise timeout_o is tied low.
module mem_access_stage #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        n_reset_i,
  input  logic        valid_i,
  input  logic        is_mem_op_i,
  input  logic        is_load_op_i,
  input  logic        is_store_op_i,
  input  logic        is_byte_op_i,
  input  logic        op_writes_rf_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  rd_i,
  output logic        stall_o,
  output logic        dmem_req_v_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ready_i,
  input  logic        dmem_resp_v_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_v_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic [1:0]  state_dbg
);

  // Handshake: request fields stay stable while dmem_req_v_o is high; a request transfers on a
  // cycle with dmem_req_v_o & dmem_ready_i, and load data is taken on dmem_resp_v_i only in RESP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        aligned, mem_start, misalign_det, is_store, abort;
  logic        byte_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic [7:0]  lane;

  assign aligned      = is_byte_op_i | (addr_i[1:0] == 2'b00);
  assign mem_start    = valid_i & is_mem_op_i & aligned;
  assign misalign_det = valid_i & is_mem_op_i & !aligned;
  // A conflicting decode with both load and store set is treated as a load.
  assign is_store     = is_store_op_i & !is_load_op_i;

  assign stall_o   = (state_q != IDLE) | ((state_q == IDLE) & mem_start);
  assign state_dbg = state_q;

  always_comb begin
    lane = 8'h00;
    case (off_q)
      2'd0: lane = dmem_rdata_i[7:0];
      2'd1: lane = dmem_rdata_i[15:8];
      2'd2: lane = dmem_rdata_i[23:16];
      2'd3: lane = dmem_rdata_i[31:24];
      default: lane = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mem_start) state_d = REQ;
      REQ: begin
        if (dmem_ready_i) state_d = dmem_we_o ? IDLE : RESP;
        else if (abort)   state_d = IDLE;
      end
      RESP: begin
        if (dmem_resp_v_i) state_d = IDLE;
        else if (abort)    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] cnt_q;
  logic             complete_now;

  // Completion in the same cycle as the limit wins over the abort.
  assign complete_now = ((state_q == REQ) & dmem_ready_i) | ((state_q == RESP) & dmem_resp_v_i);
  assign abort = (state_q != IDLE) & (cnt_q == CNT_W'(TIMEOUT_CYC)) & !complete_now;

  always_ff @(posedge clk) begin
    if (!n_reset_i) begin
      cnt_q     <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= abort;
      if (state_q == IDLE) cnt_q <= '0;
      else                 cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign abort     = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!n_reset_i) begin
      dmem_req_v_o <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_be_o    <= '0;
      wb_v_o       <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
      misalign_o   <= 1'b0;
      byte_q       <= 1'b0;
      off_q        <= '0;
      rd_q         <= '0;
    end else begin
      wb_v_o     <= 1'b0;
      wb_we_o    <= 1'b0;
      misalign_o <= (state_q == IDLE) & misalign_det;
      case (state_q)
        IDLE: begin
          if (mem_start) begin
            dmem_req_v_o <= 1'b1;
            dmem_we_o    <= is_store;
            dmem_addr_o  <= {addr_i[31:2], 2'b00};
            byte_q       <= is_byte_op_i;
            off_q        <= addr_i[1:0];
            rd_q         <= rd_i;
            if (is_store & is_byte_op_i) begin
              dmem_be_o    <= 4'b0001 << addr_i[1:0];
              dmem_wdata_o <= {4{store_data_i[7:0]}};
            end else begin
              dmem_be_o    <= 4'hF;
              dmem_wdata_o <= store_data_i;
            end
          end else if (valid_i & !is_mem_op_i) begin
            wb_v_o    <= 1'b1;
            wb_we_o   <= op_writes_rf_i & (rd_i != 5'd0);
            wb_rd_o   <= rd_i;
            wb_data_o <= addr_i;
          end
        end
        REQ: begin
          if (dmem_ready_i) begin
            dmem_req_v_o <= 1'b0;
            if (dmem_we_o) begin
              wb_v_o  <= 1'b1;
              wb_rd_o <= rd_q;
            end
          end else if (abort) begin
            dmem_req_v_o <= 1'b0;
          end
        end
        RESP: begin
          if (dmem_resp_v_i) begin
            wb_v_o    <= 1'b1;
            wb_we_o   <= (rd_q != 5'd0);
            wb_rd_o   <= rd_q;
            wb_data_o <= byte_q ? {24'h000000, lane} : dmem_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: non-memory vector table, hand-written multi-cycle sequences,
// then randomized traffic against a word-array memory model and writeback/request scoreboards.
module tb_mem_access_stage;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int TO        = 4;
  localparam int RDY_LOW   = 1;
  localparam int RSP_WAIT  = 1;
  localparam int RAND_WAIT = 1;
  localparam bit RDY_ALWAYS = 1'b1;
`else
  localparam int TO        = 255;
  localparam int RDY_LOW   = 3;
  localparam int RSP_WAIT  = 2;
  localparam int RAND_WAIT = 3;
  localparam bit RDY_ALWAYS = 1'b0;
`endif

  logic        clk, n_reset_i, valid_i;
  logic        is_mem_op_i, is_load_op_i, is_store_op_i, is_byte_op_i, op_writes_rf_i;
  logic [31:0] addr_i, store_data_i;
  logic [4:0]  rd_i;
  logic        stall_o, dmem_req_v_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ready_i, dmem_resp_v_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_v_o, wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misalign_o, timeout_o;
  logic [1:0]  state_dbg;

  mem_access_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .n_reset_i(n_reset_i), .valid_i(valid_i),
    .is_mem_op_i(is_mem_op_i), .is_load_op_i(is_load_op_i), .is_store_op_i(is_store_op_i),
    .is_byte_op_i(is_byte_op_i), .op_writes_rf_i(op_writes_rf_i),
    .addr_i(addr_i), .store_data_i(store_data_i), .rd_i(rd_i),
    .stall_o(stall_o), .dmem_req_v_o(dmem_req_v_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_ready_i(dmem_ready_i), .dmem_resp_v_i(dmem_resp_v_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_v_o(wb_v_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    valid_i = 1'b0; is_mem_op_i = 1'b0; is_load_op_i = 1'b0; is_store_op_i = 1'b0;
    is_byte_op_i = 1'b0; op_writes_rf_i = 1'b0; addr_i = '0; store_data_i = '0; rd_i = '0;
  endtask

  // ---------------- reference model ----------------
  // wb entry: {chk_data, we, rd, data}; req entry: {we, addr, be, wdata}
  logic [38:0] exp_wb[$];
  logic [68:0] exp_req[$];
  logic [31:0] ref_mem [0:63];
  logic [31:0] dmem    [0:63];
  int          exp_mis = 0;

  task automatic model_op(input logic mem, ld, st, bt, wr, input logic [31:0] a, sd, input logic [4:0] rd);
    int w, off;
    logic [3:0]  be;
    logic [31:0] wd, data;
    w   = int'(a[7:2]);
    off = int'(a[1:0]);
    if (!mem) begin
      exp_wb.push_back({1'b1, wr && (rd != 5'd0), rd, a});
    end else if (!bt && off != 0) begin
      exp_mis++;
    end else if (st && !ld) begin
      if (bt) begin
        be = 4'b0001 << off;
        wd = {4{sd[7:0]}};
        ref_mem[w][8*off +: 8] = sd[7:0];
      end else begin
        be = 4'hF;
        wd = sd;
        ref_mem[w] = sd;
      end
      exp_req.push_back({1'b1, a[31:2], 2'b00, be, wd});
      exp_wb.push_back({1'b0, 1'b0, rd, 32'h0});
    end else begin
      data = bt ? ((ref_mem[w] >> (8 * off)) & 32'hFF) : ref_mem[w];
      exp_req.push_back({1'b0, a[31:2], 2'b00, 4'hF, 32'h0});
      exp_wb.push_back({1'b1, rd != 5'd0, rd, data});
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_op(input logic mem, ld, st, bt, wr, input logic [31:0] a, sd, input logic [4:0] rd);
    int n;
    valid_i = 1'b1; is_mem_op_i = mem; is_load_op_i = ld; is_store_op_i = st;
    is_byte_op_i = bt; op_writes_rf_i = wr; addr_i = a; store_data_i = sd; rd_i = rd;
    model_op(mem, ld, st, bt, wr, a, sd, rd);
    tick();
    n = 0;
    while (state_dbg != 2'd0 && n < 100) begin
      tick();
      n++;
    end
    chk("op_done_bound", {31'b0, n < 100}, 32'd1);
    clear_inputs();
  endtask

  // ---------------- memory responder (random phase) ----------------
  logic auto_mem = 1'b0;

  initial begin : responder
    logic        acc_prev, acc_we, real_prev, pend;
    logic [31:0] acc_addr, acc_wd;
    logic [3:0]  acc_be;
    int          wait_cnt, pend_w;
    acc_prev = 0; acc_we = 0; real_prev = 0; pend = 0; wait_cnt = 0; pend_w = 0;
    acc_addr = 0; acc_wd = 0; acc_be = 0;
    forever begin
      @(posedge clk);
      #1;
      if (auto_mem) begin
        if (acc_prev) begin
          if (acc_we) begin
            for (int i = 0; i < 4; i++)
              if (acc_be[i]) dmem[acc_addr[7:2]][8*i +: 8] = acc_wd[8*i +: 8];
          end else begin
            pend     = 1'b1;
            pend_w   = int'(acc_addr[7:2]);
            wait_cnt = $urandom_range(0, RAND_WAIT);
          end
        end
        if (real_prev) pend = 1'b0;
        dmem_resp_v_i = 1'b0;
        real_prev     = 1'b0;
        dmem_rdata_i  = $urandom;
        if (pend) begin
          if (wait_cnt == 0) begin
            dmem_resp_v_i = 1'b1;
            dmem_rdata_i  = dmem[pend_w];
            real_prev     = 1'b1;
          end else begin
            wait_cnt--;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          dmem_resp_v_i = 1'b1;
        end
        dmem_ready_i = dmem_req_v_o && (RDY_ALWAYS || $urandom_range(0, 2) != 0);
        acc_prev = dmem_req_v_o && dmem_ready_i;
        acc_we   = dmem_we_o;
        acc_addr = dmem_addr_o;
        acc_be   = dmem_be_o;
        acc_wd   = dmem_wdata_o;
      end else begin
        acc_prev = 1'b0; pend = 1'b0; real_prev = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic        mon_en = 1'b0;
  logic [38:0] mon_wb;
  logic [68:0] mon_req;
  int          mis_seen = 0;
  int          to_seen  = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (wb_v_o) begin
        if (exp_wb.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
        else begin
          mon_wb = exp_wb.pop_front();
          chk("rnd_wb_we", {31'b0, wb_we_o}, {31'b0, mon_wb[37]});
          chk("rnd_wb_rd", {27'b0, wb_rd_o}, {27'b0, mon_wb[36:32]});
          if (mon_wb[38]) chk("rnd_wb_data", wb_data_o, mon_wb[31:0]);
        end
      end
      if (dmem_req_v_o && dmem_ready_i) begin
        if (exp_req.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
        else begin
          mon_req = exp_req.pop_front();
          chk("rnd_req_we", {31'b0, dmem_we_o}, {31'b0, mon_req[68]});
          chk("rnd_req_addr", dmem_addr_o, mon_req[67:36]);
          chk("rnd_req_be", {28'b0, dmem_be_o}, {28'b0, mon_req[35:32]});
          if (mon_req[68]) chk("rnd_req_wdata", dmem_wdata_o, mon_req[31:0]);
        end
      end
      if (misalign_o) mis_seen++;
      if (timeout_o) to_seen++;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- main sequence ----------------
  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] a;
    logic        exp_we;
  } nm_vec_t;

  nm_vec_t vecs[4];

  initial begin
    int to_cnt, wbc, r, w, off;
    logic mem, ld, st, bt;
    logic [31:0] a;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 32'h0;
      dmem[i]    = 32'h0;
    end
    vecs[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b1};
    vecs[1] = '{1'b1, 5'd0,  32'h0000_1234, 1'b0};
    vecs[2] = '{1'b0, 5'd7,  32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1};

    clear_inputs();
    dmem_ready_i = 1'b0; dmem_resp_v_i = 1'b0; dmem_rdata_i = '0;
    n_reset_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, stall_o}, 0);
    chk("rst_req_v", {31'b0, dmem_req_v_o}, 0);
    chk("rst_wb_v", {31'b0, wb_v_o}, 0);
    chk("rst_addr", dmem_addr_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_timeout", {31'b0, timeout_o}, 0);
    tick();
    n_reset_i = 1'b1;

    // Non-memory ops from the vector table
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; op_writes_rf_i = vecs[i].wr; rd_i = vecs[i].rd; addr_i = vecs[i].a;
      @(negedge clk);
      chk("nm_stall", {31'b0, stall_o}, 0);
      tick();
      clear_inputs();
      @(negedge clk);
      chk("nm_wb_v", {31'b0, wb_v_o}, 1);
      chk("nm_wb_we", {31'b0, wb_we_o}, {31'b0, vecs[i].exp_we});
      chk("nm_wb_rd", {27'b0, wb_rd_o}, {27'b0, vecs[i].rd});
      chk("nm_wb_data", wb_data_o, vecs[i].a);
      tick();
      @(negedge clk);
      chk("nm_wb_pulse", {31'b0, wb_v_o}, 0);
      tick();
    end

    // SB 0x1003, ready at T+1
    valid_i = 1'b1; is_mem_op_i = 1'b1; is_store_op_i = 1'b1; is_byte_op_i = 1'b1;
    addr_i = 32'h1003; store_data_i = 32'hAABBCCDD; rd_i = 5'd0;
    @(negedge clk);
    chk("sb_stall_t0", {31'b0, stall_o}, 1);
    chk("sb_noreq_t0", {31'b0, dmem_req_v_o}, 0);
    tick();
    dmem_ready_i = 1'b1;
    @(negedge clk);
    chk("sb_req_v", {31'b0, dmem_req_v_o}, 1);
    chk("sb_we", {31'b0, dmem_we_o}, 1);
    chk("sb_be", {28'b0, dmem_be_o}, 32'h8);
    chk("sb_wdata", dmem_wdata_o, 32'hDDDDDDDD);
    chk("sb_addr", dmem_addr_o, 32'h1000);
    chk("sb_stall_t1", {31'b0, stall_o}, 1);
    tick();
    dmem_ready_i = 1'b0;
    clear_inputs();
    @(negedge clk);
    chk("sb_wb_v", {31'b0, wb_v_o}, 1);
    chk("sb_wb_we", {31'b0, wb_we_o}, 0);
    chk("sb_stall_t2", {31'b0, stall_o}, 0);
    chk("sb_req_drop", {31'b0, dmem_req_v_o}, 0);
    tick();

    // LBU 0x2002, ready held low, ready+resp coincide once, response after a wait
    valid_i = 1'b1; is_mem_op_i = 1'b1; is_load_op_i = 1'b1; is_byte_op_i = 1'b1;
    addr_i = 32'h2002; rd_i = 5'd9;
    @(negedge clk);
    chk("lbu_stall_t0", {31'b0, stall_o}, 1);
    for (int j = 0; j < RDY_LOW; j++) begin
      tick();
      @(negedge clk);
      chk("lbu_req_hold", {31'b0, dmem_req_v_o}, 1);
      chk("lbu_addr_hold", dmem_addr_o, 32'h2000);
      chk("lbu_be", {28'b0, dmem_be_o}, 32'hF);
      chk("lbu_we", {31'b0, dmem_we_o}, 0);
      chk("lbu_stall_req", {31'b0, stall_o}, 1);
    end
    tick();
    dmem_ready_i = 1'b1; dmem_resp_v_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    chk("lbu_req_acc", {31'b0, dmem_req_v_o}, 1);
    tick();
    dmem_ready_i = 1'b0; dmem_resp_v_i = 1'b0;
    for (int j = 0; j < RSP_WAIT; j++) begin
      @(negedge clk);
      chk("lbu_stall_resp", {31'b0, stall_o}, 1);
      chk("lbu_req_off", {31'b0, dmem_req_v_o}, 0);
      chk("lbu_no_wb", {31'b0, wb_v_o}, 0);
      tick();
    end
    dmem_resp_v_i = 1'b1; dmem_rdata_i = 32'h11223344;
    @(negedge clk);
    chk("lbu_stall_last", {31'b0, stall_o}, 1);
    tick();
    dmem_resp_v_i = 1'b0;
    clear_inputs();
    @(negedge clk);
    chk("lbu_wb_v", {31'b0, wb_v_o}, 1);
    chk("lbu_wb_we", {31'b0, wb_we_o}, 1);
    chk("lbu_wb_rd", {27'b0, wb_rd_o}, 32'd9);
    chk("lbu_wb_data", wb_data_o, 32'h00000022);
    chk("lbu_stall_done", {31'b0, stall_o}, 0);
    tick();

    // Misaligned LW 0x3001
    valid_i = 1'b1; is_mem_op_i = 1'b1; is_load_op_i = 1'b1; addr_i = 32'h3001; rd_i = 5'd4;
    @(negedge clk);
    chk("mis_stall", {31'b0, stall_o}, 0);
    tick();
    clear_inputs();
    @(negedge clk);
    chk("mis_pulse", {31'b0, misalign_o}, 1);
    chk("mis_no_req", {31'b0, dmem_req_v_o}, 0);
    chk("mis_no_wb", {31'b0, wb_v_o}, 0);
    tick();
    @(negedge clk);
    chk("mis_pulse_end", {31'b0, misalign_o}, 0);
    chk("mis_no_wb2", {31'b0, wb_v_o}, 0);
    tick();

    // Reset while in RESP, then a late response
    valid_i = 1'b1; is_mem_op_i = 1'b1; is_load_op_i = 1'b1; addr_i = 32'h40;
    store_data_i = 32'h5A5A5A5A; rd_i = 5'd3;
    tick();
    dmem_ready_i = 1'b1;
    tick();
    dmem_ready_i = 1'b0;
    @(negedge clk);
    chk("rr_stall_resp", {31'b0, stall_o}, 1);
    tick();
    n_reset_i = 1'b0;
    clear_inputs();
    tick();
    n_reset_i = 1'b1;
    dmem_resp_v_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D;
    @(negedge clk);
    chk("rr_stall", {31'b0, stall_o}, 0);
    chk("rr_req_v", {31'b0, dmem_req_v_o}, 0);
    chk("rr_addr", dmem_addr_o, 0);
    chk("rr_wdata", dmem_wdata_o, 0);
    chk("rr_be", {28'b0, dmem_be_o}, 0);
    chk("rr_wb_v", {31'b0, wb_v_o}, 0);
    chk("rr_wb_rd", {27'b0, wb_rd_o}, 0);
    tick();
    dmem_resp_v_i = 1'b0;
    @(negedge clk);
    chk("rr_late_resp_wb", {31'b0, wb_v_o}, 0);
    chk("rr_late_resp_stall", {31'b0, stall_o}, 0);
    tick();

`ifdef MEM_STAGE_TIMEOUT_EN
    // Load that is never answered must be aborted
    valid_i = 1'b1; is_mem_op_i = 1'b1; is_load_op_i = 1'b1; addr_i = 32'h80; rd_i = 5'd6;
    tick();
    dmem_ready_i = 1'b1;
    tick();
    dmem_ready_i = 1'b0;
    to_cnt = 0;
    wbc = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (wb_v_o) wbc++;
      if (timeout_o) begin
        to_cnt++;
        chk("to_stall_drop", {31'b0, stall_o}, 0);
        chk("to_req_drop", {31'b0, dmem_req_v_o}, 0);
      end
      tick();
      if (state_dbg == 2'd0) clear_inputs();
    end
    chk("to_pulse_count", to_cnt, 1);
    chk("to_no_wb", wbc, 0);
`endif

    // Randomized traffic against the model
    exp_wb.delete();
    exp_req.delete();
    exp_mis = 0;
    mis_seen = 0;
    to_seen = 0;
    auto_mem = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 150; k++) begin
      r   = $urandom_range(0, 9);
      w   = $urandom_range(0, 15);
      off = $urandom_range(0, 3);
      mem = 1'b1; ld = 1'b0; st = 1'b0; bt = 1'b0;
      if (r < 3) begin
        mem = 1'b0;
      end else if (r == 3) begin
        off = $urandom_range(1, 3);
        ld  = $urandom_range(0, 1);
        st  = !ld;
      end else begin
        ld = (r <= 6);
        st = !ld;
        bt = $urandom_range(0, 1);
        if (!bt) off = 0;
      end
      a = {24'h0, w[5:0], off[1:0]};
      if (!mem) a = $urandom;
      drive_op(mem, ld, st, bt, 1'($urandom_range(0, 1)), a, $urandom, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) begin
        is_mem_op_i = 1'($urandom_range(0, 1));
        is_load_op_i = 1'($urandom_range(0, 1));
        addr_i = $urandom;
        tick();
        clear_inputs();
      end
    end
    repeat (10) tick();
    mon_en = 1'b0;
    auto_mem = 1'b0;
    chk("rnd_wb_drained", exp_wb.size(), 0);
    chk("rnd_req_drained", exp_req.size(), 0);
    chk("rnd_misalign_count", mis_seen, exp_mis);
    chk("rnd_timeout_count", to_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
